// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer: TCR bit positions, clock-select codes, counter width.
package timer_pkg;

  localparam int CNT_W       = 8;

  localparam int TCR_LOAD    = 7;
  localparam int TCR_UPDN    = 5;
  localparam int TCR_EN      = 4;
  localparam int TCR_CKS_MSB = 1;
  localparam int TCR_CKS_LSB = 0;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

endpackage

// File: rtl/timer_tick_gen.sv
// Count-enable tick source: a free-running 4-bit prescaler, or, with TMR_EXT_CLK_EN defined,
// a 2-flop synchronizer plus rising-edge detector on the selected external clock.
module timer_tick_gen
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  cks_e       i_cks,
`ifdef TMR_EXT_CLK_EN
  input  logic [3:0] i_clk_in,
`endif
  output logic       o_tick
);

`ifdef TMR_EXT_CLK_EN

  logic       w_sel;
  logic [1:0] r_sync;
  logic       r_prev;

  assign w_sel = i_clk_in[i_cks];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], w_sel};
      r_prev <= r_sync[1];
    end
  end

  assign o_tick = r_sync[1] & ~r_prev;

`else

  logic [3:0] r_div;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= 4'h0;
    else        r_div <= r_div + 4'h1;
  end

  // NOTE: o_tick gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_tick = 1'b0;
    case (i_cks)
      CKS_DIV2:  o_tick = r_div[0];
      CKS_DIV4:  o_tick = &r_div[1:0];
      CKS_DIV8:  o_tick = &r_div[2:0];
      CKS_DIV16: o_tick = &r_div;
    endcase
  end

`endif

endmodule

// File: rtl/timer_counter.sv
// 8-bit up/down timer with reload and sticky overflow/underflow flags.
// Define TMR_EXT_CLK_EN to count edges of external clocks on clk_in instead of the prescaler.
module timer_counter
  import timer_pkg::*;
(
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [CNT_W-1:0] reg_TDR,
  input  logic [7:0]       reg_TCR,
  input  logic             clr_ovf,
  input  logic             clr_udf,
`ifdef TMR_EXT_CLK_EN
  input  logic [3:0]       clk_in,
`endif
  output logic             tmr_ovf,
  output logic             tmr_udf,
  output logic [CNT_W-1:0] tmr_cnt
);

  logic             w_load;
  logic             w_down;
  logic             w_en;
  cks_e             w_cks;
  logic             w_tick;
  logic             w_unused_tcr;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_set_ovf;
  logic             w_set_udf;

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_udf;

  assign w_load       = reg_TCR[TCR_LOAD];
  assign w_down       = reg_TCR[TCR_UPDN];
  assign w_en         = reg_TCR[TCR_EN];
  assign w_cks        = cks_e'(reg_TCR[TCR_CKS_MSB:TCR_CKS_LSB]);
  assign w_unused_tcr = ^{reg_TCR[6], reg_TCR[3:2]};

  timer_tick_gen u_tick_gen (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .i_cks    (w_cks),
`ifdef TMR_EXT_CLK_EN
    .i_clk_in (clk_in),
`endif
    .o_tick   (w_tick)
  );

  // Load wins over counting; wrap detection is taken from the pre-edge count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
    if (w_load) begin
      w_cnt_nxt = reg_TDR;
    end else if (w_en && w_tick) begin
      if (w_down) begin
        w_cnt_nxt = r_cnt - 1'b1;
        w_set_udf = (r_cnt == '0);
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_set_ovf = &r_cnt;
      end
    end
  end

  // A set arriving on the same edge as a clear keeps the flag high.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_set_ovf | (r_ovf & ~clr_ovf);
      r_udf <= w_set_udf | (r_udf & ~clr_udf);
    end
  end

  assign tmr_cnt = r_cnt;
  assign tmr_ovf = r_ovf;
  assign tmr_udf = r_udf;

endmodule
